// File: rtl/rv_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// rv_multicycle_ctrl
//   Moore-style control FSM that runs an RV32I datapath as a multi-cycle
//   machine: FETCH -> DECODE -> EXECUTE -> (MEM) -> WB over one shared
//   instruction/data memory port with a req/ready handshake.  Counts retired
//   instructions and traps permanently on an unsupported opcode.
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   opcode          IR[6:2], held from DECODE onward
//   br_taken        branch comparator result, sampled during WB
//   mem_ready       memory completes the current request this cycle
//   mem_req/mem_we  memory request / store qualifier
//   addr_sel        memory address select (0 PC, 1 ALU result register)
//   ir_we, mdr_we   capture memory read data into IR / MDR
//   alu_a_sel       ALU operand A (0 rs1, 1 PC, 2 zero)
//   alu_b_sel       ALU operand B (0 rs2, 1 imm)
//   alu_force_add   override decoded ALU op with ADD
//   pc_we, pc_sel   PC update enable / source (0 PC+4, 1 ALU, 2 ALU & ~1)
//   rf_we, wb_sel   register write enable / source (0 ALU, 1 MDR, 2 PC+4)
//   illegal         sticky trap flag
//   state           current state encoding (debug)
//   instret         retired instruction count
// ---------------------------------------------------------------------------
module rv_multicycle_ctrl #(
  parameter int unsigned COUNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [4:0]         opcode,
  input  logic               br_taken,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_we,
  output logic               addr_sel,
  output logic               ir_we,
  output logic               mdr_we,
  output logic [1:0]         alu_a_sel,
  output logic               alu_b_sel,
  output logic               alu_force_add,
  output logic               pc_we,
  output logic [1:0]         pc_sel,
  output logic               rf_we,
  output logic [1:0]         wb_sel,
  output logic               illegal,
  output logic [2:0]         state,
  output logic [COUNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_TRAP    = 3'd5
  } state_t;

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_OPIMM  = 5'b00100;

  state_t             r_state;
  logic [COUNT_W-1:0] r_instret;

  logic w_is_load;
  logic w_is_store;
  logic w_is_branch;
  logic w_is_jal;
  logic w_is_jalr;
  logic w_is_op;
  logic w_is_lui;
  logic w_is_auipc;
  logic w_is_opimm;
  logic w_legal;

  // Opcode class decode from the held IR field
  always_comb begin
    w_is_load   = (opcode == OPC_LOAD);
    w_is_store  = (opcode == OPC_STORE);
    w_is_branch = (opcode == OPC_BRANCH);
    w_is_jal    = (opcode == OPC_JAL);
    w_is_jalr   = (opcode == OPC_JALR);
    w_is_op     = (opcode == OPC_OP);
    w_is_lui    = (opcode == OPC_LUI);
    w_is_auipc  = (opcode == OPC_AUIPC);
    w_is_opimm  = (opcode == OPC_OPIMM);
    w_legal     = w_is_load | w_is_store | w_is_branch | w_is_jal | w_is_jalr |
                  w_is_op | w_is_lui | w_is_auipc | w_is_opimm;
  end

  // State sequencing and retired-instruction counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_instret <= '0;
    end else begin
      case (r_state)
        S_FETCH:   if (mem_ready) r_state <= S_DECODE;
        S_DECODE:  r_state <= w_legal ? S_EXECUTE : S_TRAP;
        S_EXECUTE: r_state <= (w_is_load | w_is_store) ? S_MEM : S_WB;
        S_MEM:     if (mem_ready) r_state <= S_WB;
        S_WB: begin
          r_state   <= S_FETCH;
          r_instret <= r_instret + COUNT_W'(1);
        end
        S_TRAP:    r_state <= S_TRAP;
        default:   r_state <= S_TRAP;
      endcase
    end
  end

  // Output decode from the current state; the only input terms are the
  // ready-qualified capture strobes and the WB branch decision.
  always_comb begin
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    addr_sel      = 1'b0;
    ir_we         = 1'b0;
    mdr_we        = 1'b0;
    alu_a_sel     = 2'd0;
    alu_b_sel     = 1'b0;
    alu_force_add = 1'b0;
    pc_we         = 1'b0;
    pc_sel        = 2'd0;
    rf_we         = 1'b0;
    wb_sel        = 2'd0;
    illegal       = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_req = 1'b1;
        // Keep the capture strobe quiet while reset is asserted
        ir_we   = mem_ready & ~rst;
      end
      S_DECODE: begin
      end
      S_EXECUTE: begin
        if (w_is_op) begin
          alu_a_sel     = 2'd0;
          alu_b_sel     = 1'b0;
          alu_force_add = 1'b0;
        end else if (w_is_opimm) begin
          alu_a_sel     = 2'd0;
          alu_b_sel     = 1'b1;
          alu_force_add = 1'b0;
        end else if (w_is_lui) begin
          alu_a_sel     = 2'd2;
          alu_b_sel     = 1'b1;
          alu_force_add = 1'b1;
        end else if (w_is_auipc | w_is_jal | w_is_branch) begin
          alu_a_sel     = 2'd1;
          alu_b_sel     = 1'b1;
          alu_force_add = 1'b1;
        end else begin
          // LOAD / STORE / JALR: address or target = rs1 + imm
          alu_a_sel     = 2'd0;
          alu_b_sel     = 1'b1;
          alu_force_add = 1'b1;
        end
      end
      S_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = w_is_store;
        mdr_we   = mem_ready & w_is_load;
      end
      S_WB: begin
        pc_we = 1'b1;
        if (w_is_jal) begin
          pc_sel = 2'd1;
        end else if (w_is_jalr) begin
          pc_sel = 2'd2;
        end else if (w_is_branch) begin
          pc_sel = br_taken ? 2'd1 : 2'd0;
        end else begin
          pc_sel = 2'd0;
        end
        rf_we = ~(w_is_store | w_is_branch);
        if (w_is_load) begin
          wb_sel = 2'd1;
        end else if (w_is_jal | w_is_jalr) begin
          wb_sel = 2'd2;
        end else begin
          wb_sel = 2'd0;
        end
      end
      S_TRAP: begin
        illegal = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign state   = r_state;
  assign instret = r_instret;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
module tb_rv_multicycle_ctrl;

  localparam int unsigned COUNT_W = 32;

  localparam logic [4:0] LOAD   = 5'b00000;
  localparam logic [4:0] STORE  = 5'b01000;
  localparam logic [4:0] BRANCH = 5'b11000;
  localparam logic [4:0] JAL    = 5'b11011;
  localparam logic [4:0] JALR   = 5'b11001;
  localparam logic [4:0] OP     = 5'b01100;
  localparam logic [4:0] LUI    = 5'b01101;
  localparam logic [4:0] AUIPC  = 5'b00101;
  localparam logic [4:0] OPIMM  = 5'b00100;

  logic               clk;
  logic               rst;
  logic [4:0]         opcode;
  logic               br_taken;
  logic               mem_ready;
  logic               mem_req;
  logic               mem_we;
  logic               addr_sel;
  logic               ir_we;
  logic               mdr_we;
  logic [1:0]         alu_a_sel;
  logic               alu_b_sel;
  logic               alu_force_add;
  logic               pc_we;
  logic [1:0]         pc_sel;
  logic               rf_we;
  logic [1:0]         wb_sel;
  logic               illegal;
  logic [2:0]         state;
  logic [COUNT_W-1:0] instret;

  rv_multicycle_ctrl #(.COUNT_W(COUNT_W)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .br_taken(br_taken),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .addr_sel(addr_sel), .ir_we(ir_we), .mdr_we(mdr_we),
    .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
    .alu_force_add(alu_force_add), .pc_we(pc_we), .pc_sel(pc_sel),
    .rf_we(rf_we), .wb_sel(wb_sel), .illegal(illegal), .state(state),
    .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Expected per-instruction behaviour, from the opcode table
  typedef struct {
    logic [4:0]  opc;
    int          cycles;
    logic [1:0]  a;
    logic        b;
    logic        f;
    logic [1:0]  pcs;
    logic        rfwe;
    logic [1:0]  wbs;
    int          memc;
    int          mwec;
    int          mdrc;
    logic [31:0] inst;
  } exp_t;

  exp_t        q[$];
  int unsigned n_ret = 0;

  function automatic exp_t model(input logic [4:0] opc, input logic br,
                                 input int fs, input int ms, input int unsigned nret);
    exp_t e;
    bit   ld, st;
    ld = 0; st = 0;
    e.opc = opc; e.a = 2'd0; e.b = 1'b1; e.f = 1'b1;
    e.pcs = 2'd0; e.rfwe = 1'b1; e.wbs = 2'd0;
    case (opc)
      OP:     begin e.b = 1'b0; e.f = 1'b0; end
      OPIMM:  e.f = 1'b0;
      LOAD:   begin ld = 1; e.wbs = 2'd1; end
      STORE:  begin st = 1; e.rfwe = 1'b0; end
      JALR:   begin e.pcs = 2'd2; e.wbs = 2'd2; end
      LUI:    e.a = 2'd2;
      AUIPC:  e.a = 2'd1;
      JAL:    begin e.a = 2'd1; e.pcs = 2'd1; e.wbs = 2'd2; end
      BRANCH: begin e.a = 2'd1; e.pcs = br ? 2'd1 : 2'd0; e.rfwe = 1'b0; end
      default: ;
    endcase
    e.cycles = 4 + fs + ((ld || st) ? 1 + ms : 0);
    e.memc   = (ld || st) ? 1 + ms : 0;
    e.mwec   = st ? 1 + ms : 0;
    e.mdrc   = ld ? 1 : 0;
    e.inst   = 32'(nret);
    return e;
  endfunction

  // Monitor: accumulates per-instruction observations, compares at retire
  bit          mon_en = 0;
  int          cyc, memc, mwec, mdrc, irc;
  logic [1:0]  ca;
  logic        cb, cf;
  bit          membad;
  bit          pend;
  logic [31:0] pend_val;

  always @(negedge clk) begin
    if (!mon_en) begin
      cyc = 0; memc = 0; mwec = 0; mdrc = 0; irc = 0; membad = 0; pend = 0;
      ca = 2'd3; cb = 1'bx; cf = 1'bx;
    end else begin
      if (pend) begin
        chk("instret_inc", instret, pend_val);
        pend = 0;
      end
      cyc++;
      if (ir_we) irc++;
      if (mdr_we) mdrc++;
      if (state == 3'd2) begin ca = alu_a_sel; cb = alu_b_sel; cf = alu_force_add; end
      if (state == 3'd3) begin
        memc++;
        if (mem_we) mwec++;
        if (!(mem_req && addr_sel)) membad = 1;
      end
      if (state == 3'd4) begin
        if (q.size() == 0) begin
          chk("unexpected_retire", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("cycles",    cyc,           e.cycles);
          chk("alu_a_sel", ca,            e.a);
          chk("alu_b_sel", cb,            e.b);
          chk("force_add", cf,            e.f);
          chk("mem_cycles", memc,         e.memc);
          chk("mem_we_cycles", mwec,      e.mwec);
          chk("mem_req_addr", membad,     0);
          chk("mdr_we_pulses", mdrc,      e.mdrc);
          chk("ir_we_pulses", irc,        1);
          chk("pc_we",     pc_we,         1);
          chk("pc_sel",    pc_sel,        e.pcs);
          chk("rf_we",     rf_we,         e.rfwe);
          chk("wb_sel",    wb_sel,        e.wbs);
          chk("wb_mem_req", mem_req,      0);
          chk("illegal",   illegal,       0);
          chk("instret",   instret,       e.inst);
          pend = 1; pend_val = e.inst + 32'd1;
        end
        cyc = 0; memc = 0; mwec = 0; mdrc = 0; irc = 0; membad = 0;
        ca = 2'd3; cb = 1'bx; cf = 1'bx;
      end
    end
  end

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic step(input logic rdy, input logic br);
    mem_ready = rdy;
    br_taken  = br;
    @(posedge clk);
    #1;
  endtask

  // Drive one instruction with a planned number of FETCH and MEM stalls
  task automatic run_instr(input logic [4:0] opc, input logic br, input int fs, input int ms);
    q.push_back(model(opc, br, fs, ms, n_ret));
    n_ret++;
    for (int k = 0; k < fs; k++) begin
      opcode = 5'($urandom);
      step(1'b0, rb());
    end
    opcode = 5'($urandom);
    step(1'b1, rb());
    opcode = opc;
    step(rb(), rb());
    step(rb(), rb());
    if (opc == LOAD || opc == STORE) begin
      for (int k = 0; k < ms; k++) step(1'b0, rb());
      step(1'b1, rb());
    end
    step(rb(), br);
  endtask

  task automatic drain();
    for (int t = 0; t < 200 && q.size() != 0; t++) step(1'b1, 1'b0);
    chk("drain", q.size(), 0);
    step(1'b0, 1'b0);
  endtask

  logic [4:0] legal_ops [9];

  initial begin
    legal_ops = '{LOAD, STORE, BRANCH, JAL, JALR, OP, LUI, AUIPC, OPIMM};
    rst = 1'b1; mem_ready = 1'b0; opcode = 5'd0; br_taken = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state",   state,   0);
    chk("rst_mem_req", mem_req, 1);
    chk("rst_addr_sel", addr_sel, 0);
    chk("rst_ir_we",   ir_we,   0);
    chk("rst_pc_we",   pc_we,   0);
    chk("rst_rf_we",   rf_we,   0);
    chk("rst_illegal", illegal, 0);
    chk("rst_instret", instret, 0);

    rst = 1'b0;
    mon_en = 1;
    // Directed sequence from the test plan
    run_instr(OPIMM,  1'b0, 0, 0);
    run_instr(LOAD,   1'b0, 0, 3);
    run_instr(STORE,  1'b0, 0, 0);
    run_instr(BRANCH, 1'b1, 0, 0);
    run_instr(BRANCH, 1'b0, 0, 0);
    run_instr(JAL,    1'b0, 0, 0);
    run_instr(JALR,   1'b0, 0, 0);
    // Randomized instruction stream with random stalls
    for (int i = 0; i < 60; i++) begin
      run_instr(legal_ops[$urandom_range(0, 8)], rb(),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
    drain();
    mon_en = 0;

    // Reset asserted in the middle of a FETCH stall
    step(1'b0, 1'b0);
    #3;
    rst = 1'b1;
    n_ret = 0;
    #1;
    chk("midrst_state",   state,   0);
    chk("midrst_illegal", illegal, 0);
    chk("midrst_instret", instret, 0);
    chk("midrst_mem_req", mem_req, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1;
    run_instr(OP,  1'b0, 1, 0);
    run_instr(LUI, 1'b0, 0, 0);
    drain();
    mon_en = 0;

    // Illegal opcode: FETCH (state already), DECODE, then TRAP
    opcode = 5'b11111;
    step(1'b1, 1'b0);
    chk("ill_decode_state", state, 1);
    step(1'b1, 1'b0);
    chk("trap_state",   state,   5);
    chk("trap_illegal", illegal, 1);
    for (int k = 0; k < 10; k++) begin
      chk("trap_hold_state", state,   5);
      chk("trap_mem_req",    mem_req, 0);
      chk("trap_enables",    {ir_we, mdr_we, pc_we, rf_we}, 0);
      chk("trap_instret",    instret, 2);
      step(rb(), rb());
    end
    rst = 1'b1;
    #1;
    chk("trap_rst_state",   state,   0);
    chk("trap_rst_illegal", illegal, 0);
    chk("trap_rst_instret", instret, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
